im_loader: RTL and testbench
============================

# im_loader

Boot-time instruction memory writer. It accepts a byte stream over a valid/ready handshake and writes each byte into the byte-addressed instruction memory IM (`INSTR_MAX` bytes, big-endian words). It then reads the image back through IM's word read port (`InstrAddr`/`Instr`) and checks it against a running checksum. It sits between the host/testbench stream source and IM, and holds the processor off (`Busy`) until the image is loaded and verified.

## Interface
Parameters:
- `INSTR_MAX`, 128: IM capacity in bytes.
- `INSTR_SIZE`, 8: IM cell width in bits; the stream byte width.

Ports:
- `clk`, in, 1: single clock. All state changes on the rising edge.
- `rst`, in, 1: reset, synchronous and active-high.
- `Start`, in, 1: one-cycle load request. Sampled only in IDLE.
- `Len`, in, 8: image length in bytes. Sampled with `Start`.
- `InByte`, in, `INSTR_SIZE`: stream data.
- `InValid`, in, 1: stream data valid.
- `InReady`, out, 1: loader accepts a byte. High only in LOAD.
- `MemWrite`, out, 1: IM byte write enable.
- `MemAddr`, out, 32: IM byte write address.
- `MemWData`, out, `INSTR_SIZE`: IM byte write data.
- `InstrAddr`, out, 32: IM word read address (verify phase).
- `Instr`, in, 32: IM read data. Combinational, big-endian: byte[a] is bits [31:24].
- `Busy`, out, 1: high in LOAD and VERIFY.
- `Done`, out, 1: one-cycle pulse at end of verify.
- `Pass`, out, 1: verify result. Valid from `Done` and held until the next accepted `Start`.
- `Error`, out, 1: one-cycle pulse when a `Start` is rejected.

## Operation
- States: IDLE, LOAD, VERIFY, DONE.
- IDLE with `Start=1`:
  - Reject if `Len==0`, `Len>INSTR_MAX`, or `Len[1:0]!=0`. Pulse `Error` next cycle and stay in IDLE. `Pass` is unchanged.
  - Otherwise latch `Len`, clear `ByteCnt`, `WordAddr`, `WrSum` and `RdSum`, clear `Pass`, and go to LOAD.
- LOAD:
  - `InReady=1`.
  - `MemWrite = InValid`, `MemAddr = ByteCnt` (zero-extended), `MemWData = InByte`, all combinational. IM captures the byte at the same edge.
  - On each transfer, `ByteCnt += 1` and `WrSum += InByte` (16-bit, mod 2^16).
  - When the transfer with `ByteCnt == Len-1` completes, go to VERIFY.
  - `InValid=0` stalls indefinitely with no timeout.
- VERIFY:
  - `InstrAddr = WordAddr` (registered, starts at 0).
  - Each cycle, add `Instr[31:24] + Instr[23:16] + Instr[15:8] + Instr[7:0]` into `RdSum` (16-bit), then `WordAddr += 4`.
  - After `Len/4` words, go to DONE.
- DONE, one cycle:
  - `Done=1`.
  - `Pass` is registered as `(RdSum == WrSum)`.
  - Return to IDLE.
- `Start` outside IDLE is ignored; no `Error`. `InValid` outside LOAD is ignored; no write.
- `InstrAddr` holds its last value outside VERIFY. It is 0 after reset.

## Timing
- Reset values: state IDLE, and all outputs 0 (`InReady`, `MemWrite`, `MemAddr`, `MemWData`, `InstrAddr`, `Busy`, `Done`, `Pass`, `Error`). All counters and sums are 0.
- Reset asserted mid-LOAD or mid-VERIFY:
  - The next cycle is IDLE with reset values.
  - IM contents are left as written; no further writes occur.
  - `Done` does not pulse.
- Latency with `Start` accepted at edge 0 and `InValid` held high:
  - LOAD occupies cycles 1..N.
  - VERIFY occupies cycles N+1..N+N/4.
  - `Done` is high in cycle N+N/4+1.
  - The next `Start` can be accepted in cycle N+N/4+2.
- Each `InValid` low cycle during LOAD delays all later events by one cycle.
- Boundary: `Len == INSTR_MAX` (128) is legal. The last write is to address 127 and the last read is `InstrAddr=124`.
- `Len=128` with all bytes FF gives `WrSum = 0x7F80`, with no overflow. Wrap mod 2^16 is still defined.

## Test plan
- Load 8 bytes A0 0B 11 AC 12 32 B0 12 with `InValid` continuous:
  - Writes occur at addresses 0..7.
  - `InstrAddr` is 0 in cycle 9, then 4.
  - `Instr` at 0 = A00B11AC and at 4 = 1232B012.
  - `WrSum = RdSum = 0x026E`.
  - `Done` and `Pass=1` in cycle 11.
- Same image with `InValid` low for cycles 3–4:
  - No write in those cycles.
  - `Done` moves to cycle 13 and `Pass=1`.
- `Start` with `Len` = 0, then 6, then 132:
  - `Error` pulses each time.
  - State stays IDLE, and `Busy`, `InReady` and `MemWrite` stay 0.
- After a good 8-byte LOAD, the bench forces IM byte 5 to 00 before word 4 is read:
  - `RdSum = 0x023C`, which differs from `WrSum`.
  - `Done=1` with `Pass=0`.
- Assert `rst` after the 3rd byte of an 8-byte load:
  - All outputs are 0 next cycle.
  - There is no `Done` pulse.
  - A fresh `Start` with `Len=4` loads and passes.
- `Len=128`, bytes equal to their address (00..7F):
  - The last write is at 127.
  - `WrSum = 0x1FC0`.
  - `Done` is in cycle 161 and `Pass=1`.

Source files
------------

// File: rtl/im_loader.sv
// im_loader -- boot-time instruction memory writer and verifier.
//
// Accepts an image of Len bytes over a valid/ready byte stream and writes
// each byte into the byte-addressed instruction memory IM. It then reads the
// image back one big-endian word per cycle through IM's combinational word
// port and compares a 16-bit byte checksum of what was read against the
// checksum of what was written. The processor is held off with Busy for the
// whole load and verify sequence.
//
// Ports:
//   clk, rst         clock; synchronous active-high reset
//   Start, Len       one-cycle load request and image length (sampled in IDLE)
//   InByte, InValid  stream data and valid
//   InReady          stream ready (high only while loading)
//   MemWrite, MemAddr, MemWData   IM byte write port (combinational)
//   InstrAddr, Instr              IM word read port (verify phase)
//   Busy             high while loading or verifying
//   Done             one-cycle pulse at the end of verify
//   Pass             verify result, held until the next accepted Start
//   Error            one-cycle pulse after a rejected Start

module im_loader #(
  parameter int INSTR_MAX  = 128,
  parameter int INSTR_SIZE = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  Start,
  input  logic [7:0]            Len,
  input  logic [INSTR_SIZE-1:0] InByte,
  input  logic                  InValid,
  output logic                  InReady,
  output logic                  MemWrite,
  output logic [31:0]           MemAddr,
  output logic [INSTR_SIZE-1:0] MemWData,
  output logic [31:0]           InstrAddr,
  input  logic [31:0]           Instr,
  output logic                  Busy,
  output logic                  Done,
  output logic                  Pass,
  output logic                  Error
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    VERIFY = 2'd2,
    DONE   = 2'd3
  } stateT;

  localparam logic [8:0] MAX_LEN = 9'(INSTR_MAX);

  stateT       stateReg, stateNext;
  logic [7:0]  lenReg;
  logic [7:0]  byteCnt;
  logic [31:0] wordAddr;
  logic [15:0] wrSum;
  logic [15:0] rdSum;
  logic        passReg;
  logic        errorReg;

  // Control strobes decoded from the current state and inputs.
  logic        lenBad;
  logic        acceptStart;
  logic        rejectStart;
  logic        xfer;
  logic        lastByte;
  logic        lastWord;
  logic [15:0] wordSum;
  logic [15:0] rdSumNext;

  // Split the read word into its four bytes, each zero-extended to the
  // checksum width.
  logic [15:0] instrByte [4];

  for (genvar gi = 0; gi < 4; gi++) begin : gByte
    assign instrByte[gi] = {8'd0, Instr[31-8*gi -: 8]};
  end

  assign wordSum   = instrByte[0] + instrByte[1] + instrByte[2] + instrByte[3];
  assign rdSumNext = rdSum + wordSum;

  // Only whole words that fit in IM are loadable.
  assign lenBad      = (Len == 8'd0) || ({1'b0, Len} > MAX_LEN) || (Len[1:0] != 2'b00);
  assign acceptStart = (stateReg == IDLE) && Start && !lenBad;
  assign rejectStart = (stateReg == IDLE) && Start && lenBad;
  assign xfer        = (stateReg == LOAD) && InValid;
  assign lastByte    = xfer && (byteCnt == lenReg - 8'd1);
  // Len is at most 128, so the 8-bit sum cannot wrap before matching.
  assign lastWord    = (stateReg == VERIFY) && ((wordAddr[7:0] + 8'd4) == lenReg);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      stateReg <= IDLE;
    end else begin
      stateReg <= stateNext;
    end
  end

  // Next-state and combinational outputs.
  always_comb begin
    stateNext = stateReg;
    InReady   = 1'b0;
    MemWrite  = 1'b0;
    MemAddr   = 32'd0;
    MemWData  = '0;
    Busy      = 1'b0;
    Done      = 1'b0;

    case (stateReg)
      IDLE: begin
        if (acceptStart) begin
          stateNext = LOAD;
        end
      end
      LOAD: begin
        InReady  = 1'b1;
        Busy     = 1'b1;
        MemWrite = InValid;
        MemAddr  = {24'd0, byteCnt};
        MemWData = InByte;
        if (lastByte) begin
          stateNext = VERIFY;
        end
      end
      VERIFY: begin
        Busy = 1'b1;
        if (lastWord) begin
          stateNext = DONE;
        end
      end
      DONE: begin
        Done      = 1'b1;
        stateNext = IDLE;
      end
      default: begin
        stateNext = IDLE;
      end
    endcase
  end

  // Datapath: counters, checksums and registered flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      lenReg   <= 8'd0;
      byteCnt  <= 8'd0;
      wordAddr <= 32'd0;
      wrSum    <= 16'd0;
      rdSum    <= 16'd0;
      passReg  <= 1'b0;
      errorReg <= 1'b0;
    end else begin
      errorReg <= rejectStart;

      if (acceptStart) begin
        lenReg   <= Len;
        byteCnt  <= 8'd0;
        wordAddr <= 32'd0;
        wrSum    <= 16'd0;
        rdSum    <= 16'd0;
        passReg  <= 1'b0;
      end

      if (xfer) begin
        byteCnt <= byteCnt + 8'd1;
        wrSum   <= wrSum + 16'(InByte);
      end

      if (stateReg == VERIFY) begin
        rdSum <= rdSumNext;
        if (lastWord) begin
          // Compare with the final word already folded in so that Pass is
          // valid in the same cycle that Done is high. InstrAddr stays on
          // the last word read.
          passReg <= (rdSumNext == wrSum);
        end else begin
          wordAddr <= wordAddr + 32'd4;
        end
      end
    end
  end

  assign InstrAddr = wordAddr;
  assign Pass      = passReg;
  assign Error     = errorReg;

endmodule

// File: tb/tb_im_loader.sv
// Testbench for im_loader: directed loads with a byte-array IM model.
// Expected writes, verify addresses, Done events and Error events are queued
// by the stimulus; a negedge monitor pops and compares them whenever the DUT
// presents the corresponding output.

module tb_im_loader;

  logic        clk = 1'b0;
  logic        rst;
  logic        Start;
  logic [7:0]  Len;
  logic [7:0]  InByte;
  logic        InValid;
  logic        InReady;
  logic        MemWrite;
  logic [31:0] MemAddr;
  logic [7:0]  MemWData;
  logic [31:0] InstrAddr;
  logic [31:0] Instr;
  logic        Busy;
  logic        Done;
  logic        Pass;
  logic        Error;

  im_loader #(.INSTR_MAX(128), .INSTR_SIZE(8)) dut (
    .clk(clk), .rst(rst), .Start(Start), .Len(Len), .InByte(InByte),
    .InValid(InValid), .InReady(InReady), .MemWrite(MemWrite),
    .MemAddr(MemAddr), .MemWData(MemWData), .InstrAddr(InstrAddr),
    .Instr(Instr), .Busy(Busy), .Done(Done), .Pass(Pass), .Error(Error)
  );

  always #5 clk = ~clk;

  int edgeCnt = 0;
  always @(posedge clk) edgeCnt <= edgeCnt + 1;

  // IM model: byte array, synchronous byte write, combinational word read.
  logic [7:0] im [128];
  logic       corruptReq = 1'b0;
  always @(posedge clk) begin
    if (MemWrite) im[MemAddr[6:0]] <= MemWData;
    if (corruptReq) im[5] <= 8'h00;
  end
  logic [6:0] rdBase;
  assign rdBase = {InstrAddr[6:2], 2'b00};
  assign Instr  = {im[rdBase], im[rdBase + 7'd1], im[rdBase + 7'd2], im[rdBase + 7'd3]};

  typedef struct { int addr; logic [7:0] data; } wrExpT;
  typedef struct { int cyc; logic pass; } doneExpT;
  wrExpT   wrQ[$];
  doneExpT doneQ[$];
  int      vaQ[$];
  int      errQ[$];

  int nCompared   = 0;
  int nMismatched = 0;

  logic [7:0] img [128];
  logic [7:0] pat8 [8] = '{8'hA0, 8'h0B, 8'h11, 8'hAC, 8'h12, 8'h32, 8'hB0, 8'h12};

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    nCompared++;
    if (act !== exp) begin
      nMismatched++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor / scoreboard.
  always @(negedge clk) begin : monitor
    wrExpT   w;
    doneExpT d;
    int      a;
    if (MemWrite) begin
      nCompared++;
      if (wrQ.size() == 0) begin
        nMismatched++;
        $display("FAIL write: unexpected write addr=%0d data=%02h", MemAddr, MemWData);
      end else begin
        w = wrQ.pop_front();
        if (MemAddr != 32'(w.addr) || MemWData != w.data) begin
          nMismatched++;
          $display("FAIL write: got addr=%0d data=%02h expected addr=%0d data=%02h",
                   MemAddr, MemWData, w.addr, w.data);
        end
      end
    end
    if (Busy && !InReady) begin
      nCompared++;
      if (vaQ.size() == 0) begin
        nMismatched++;
        $display("FAIL verify_addr: unexpected verify cycle InstrAddr=%0d", InstrAddr);
      end else begin
        a = vaQ.pop_front();
        if (InstrAddr != 32'(a)) begin
          nMismatched++;
          $display("FAIL verify_addr: got %0d expected %0d", InstrAddr, a);
        end
      end
    end
    if (Done) begin
      nCompared++;
      if (doneQ.size() == 0) begin
        nMismatched++;
        $display("FAIL done: unexpected Done at edge count %0d", edgeCnt);
      end else begin
        d = doneQ.pop_front();
        if (edgeCnt != d.cyc || Pass != d.pass) begin
          nMismatched++;
          $display("FAIL done: got cycle=%0d Pass=%0b expected cycle=%0d Pass=%0b",
                   edgeCnt, Pass, d.cyc, d.pass);
        end else begin
          $display("done ok: cycle=%0d Pass=%0b", edgeCnt, Pass);
        end
      end
    end
    if (Error) begin
      nCompared++;
      if (errQ.size() == 0) begin
        nMismatched++;
        $display("FAIL error: unexpected Error at edge count %0d", edgeCnt);
      end else begin
        a = errQ.pop_front();
        if (edgeCnt != a) begin
          nMismatched++;
          $display("FAIL error: got cycle=%0d expected cycle=%0d", edgeCnt, a);
        end else begin
          $display("error ok: cycle=%0d", edgeCnt);
        end
      end
    end
  end

  function automatic logic [63:0] allOutputs();
    return {InReady, MemWrite, MemAddr, MemWData, Busy, Done, Pass, Error} |
           {32'd0, InstrAddr};
  endfunction

  // One load of img[0..len-1]. Cycle k counts from 1 after the Start edge.
  // stallFrom..stallTo: cycles with InValid low. abortAfter: assert rst once
  // that many bytes were accepted. corrupt: zero IM byte 5 during verify.
  task automatic runLoad(input int len, input int stallFrom, input int stallTo,
                         input int abortAfter, input bit corrupt,
                         input int expDone, input logic expPass);
    int s, idx, k, t;
    @(negedge clk);
    Start = 1'b1;
    Len   = 8'(len);
    s     = edgeCnt;
    if (abortAfter == 0) begin
      doneQ.push_back('{s + expDone, expPass});
      for (int a = 0; a < len; a += 4) vaQ.push_back(a);
    end
    idx = 0;
    k   = 0;
    while (idx < len && k < 400) begin
      @(negedge clk);
      k++;
      Start = 1'b0;
      if (abortAfter != 0 && idx == abortAfter) begin
        InValid = 1'b0;
        rst     = 1'b1;
        break;
      end
      if (k >= stallFrom && k <= stallTo) begin
        InValid = 1'b0;
      end else begin
        InValid = 1'b1;
        InByte  = img[idx];
      end
      if (InReady && InValid) begin
        wrQ.push_back('{idx, img[idx]});
        idx++;
      end
    end
    if (abortAfter != 0) begin
      @(negedge clk);
      rst = 1'b0;
      chk("outputs_after_abort_reset", allOutputs(), 64'd0);
      @(negedge clk);
      return;
    end
    chk("load_bytes_accepted", 64'(idx), 64'(len));
    @(negedge clk);
    InValid = 1'b0;
    if (corrupt) begin
      corruptReq = 1'b1;
      @(negedge clk);
      corruptReq = 1'b0;
    end
    t = 0;
    while (Busy && t < 400) begin
      @(negedge clk);
      t++;
    end
    chk("busy_released", 64'(Busy), 64'd0);
    repeat (2) @(negedge clk);
  endtask

  task automatic rejectStart(input int len);
    int s;
    @(negedge clk);
    Start = 1'b1;
    Len   = 8'(len);
    s     = edgeCnt;
    errQ.push_back(s + 1);
    @(negedge clk);
    Start = 1'b0;
    chk($sformatf("reject_len%0d_busy_ready_write", len), 64'({Busy, InReady, MemWrite}), 64'd0);
    chk($sformatf("reject_len%0d_pass_held", len), 64'(Pass), 64'd1);
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; Start = 1'b0; Len = 8'd0; InByte = 8'd0; InValid = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("reset_outputs", allOutputs(), 64'd0);

    for (int i = 0; i < 8; i++) img[i] = pat8[i];
    // Continuous stream: Done in cycle 11, checksums 0x026E match.
    runLoad(8, 0, -1, 0, 1'b0, 11, 1'b1);
    // InValid low in cycles 3-4: Done moves to cycle 13.
    runLoad(8, 3, 4, 0, 1'b0, 13, 1'b1);
    // Illegal lengths: Error pulse, Pass from last load stays 1.
    rejectStart(0);
    rejectStart(6);
    rejectStart(132);
    // IM byte 5 zeroed before word 4 is read: RdSum 0x023C, Pass 0.
    runLoad(8, 0, -1, 0, 1'b1, 11, 1'b0);
    // Reset after the 3rd byte: no Done, then a fresh 4-byte load passes.
    runLoad(8, 0, -1, 3, 1'b0, 0, 1'b0);
    runLoad(4, 0, -1, 0, 1'b0, 6, 1'b1);
    // Full-size image with bytes equal to their address: Done in cycle 161.
    for (int i = 0; i < 128; i++) img[i] = 8'(i);
    runLoad(128, 0, -1, 0, 1'b0, 161, 1'b1);

    chk("write_queue_drained", 64'(wrQ.size()), 64'd0);
    chk("verify_queue_drained", 64'(vaQ.size()), 64'd0);
    chk("done_queue_drained", 64'(doneQ.size()), 64'd0);
    chk("error_queue_drained", 64'(errQ.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
